// File: rtl/wb_write_buffer_if.sv
// Bus bundle for wb_write_buffer: result push port, register-file write port,
// hazard probe and occupancy. The slave modport is the buffer's view.
interface wb_write_buffer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [ADDR_W-1:0]          in_address_i;
  logic [DATA_W-1:0]          in_data_i;
  logic                       drain_hold_i;
  logic                       wb_en_o;
  logic [ADDR_W-1:0]          wb_address_o;
  logic [DATA_W-1:0]          wb_data_o;
  logic [ADDR_W-1:0]          hz_src_i;
  logic                       hz_hit_o;
  logic [DATA_W-1:0]          fwd_data_o;
  logic [$clog2(DEPTH):0]     count_o;

  modport slave (
    input  in_valid_i, in_address_i, in_data_i, drain_hold_i, hz_src_i,
    output in_ready_o, wb_en_o, wb_address_o, wb_data_o, hz_hit_o, fwd_data_o, count_o
  );

  modport master (
    output in_valid_i, in_address_i, in_data_i, drain_hold_i, hz_src_i,
    input  in_ready_o, wb_en_o, wb_address_o, wb_data_o, hz_hit_o, fwd_data_o, count_o
  );
endinterface

// File: rtl/wb_write_buffer.sv
// Register-file write buffer: FIFO of completed results drained one write per cycle,
// with hazard reporting. Define FORWARD_EN to build youngest-match data forwarding.
module wb_write_buffer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic              clk,
  input logic              rst,
  wb_write_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_address_q, wb_address_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic in_ready;
  logic push;
  logic pop;

  // Readiness depends only on stored occupancy, so a full buffer never refills on a draining edge.
  assign in_ready = (count_q != FULL_CNT);
  assign push     = bus.in_valid_i && in_ready;
  assign pop      = (count_q != '0) && !bus.drain_hold_i;

  always_comb begin
    addr_d       = addr_q;
    data_d       = data_q;
    valid_d      = valid_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    wb_en_d      = 1'b0;
    wb_address_d = wb_address_q;
    wb_data_d    = wb_data_q;

    if (push) begin
      addr_d[wr_ptr_q]  = bus.in_address_i;
      data_d[wr_ptr_q]  = bus.in_data_i;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      wb_en_d           = 1'b1;
      wb_address_d      = addr_q[rd_ptr_q];
      wb_data_d         = data_q[rd_ptr_q];
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wb_en_q      <= 1'b0;
      wb_address_q <= '0;
      wb_data_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wb_en_q      <= wb_en_d;
      wb_address_q <= wb_address_d;
      wb_data_q    <= wb_data_d;
    end
  end

  // Payload storage is qualified by valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  logic hz_hit;

  always_comb begin
    hz_hit = wb_en_q && (wb_address_q == bus.hz_src_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == bus.hz_src_i)) begin
        hz_hit = 1'b1;
      end
    end
  end

`ifdef FORWARD_EN
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  fwd_idx;

  // Walk oldest to newest so the youngest queued match wins over older ones and the wb stage.
  always_comb begin
    fwd_data = '0;
    fwd_idx  = '0;
    if (wb_en_q && (wb_address_q == bus.hz_src_i)) begin
      fwd_data = wb_data_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PTR_W'(k);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx] == bus.hz_src_i)) begin
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign bus.fwd_data_o = fwd_data;
`else
  assign bus.fwd_data_o = '0;
`endif

  assign bus.in_ready_o   = in_ready;
  assign bus.wb_en_o      = wb_en_q;
  assign bus.wb_address_o = wb_address_q;
  assign bus.wb_data_o    = wb_data_q;
  assign bus.hz_hit_o     = hz_hit;
  assign bus.count_o      = count_q;

endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed self-checking bench for wb_write_buffer; inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_wb_write_buffer;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst;
  int   checksTotal;
  int   checksPassed;

  wb_write_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  wb_write_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data);
    bus.in_valid_i   = valid;
    bus.in_address_i = addr;
    bus.in_data_i    = data;
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    checksTotal++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    else
      checksPassed++;
  endtask

  function automatic logic [DATA_W-1:0] fwdExpect(input logic [DATA_W-1:0] value);
`ifdef FORWARD_EN
    return value;
`else
    return (value == value) ? '0 : '0;
`endif
  endfunction

  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    rst = 1'b1;
    bus.drain_hold_i = 1'b0;
    bus.hz_src_i     = '0;
    applyStimulus(1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    checkOutput("rst_count", 32'(bus.count_o), 32'd0);
    checkOutput("rst_wb_en", 32'(bus.wb_en_o), 32'd0);
    checkOutput("rst_wb_addr", 32'(bus.wb_address_o), 32'd0);
    checkOutput("rst_wb_data", bus.wb_data_o, 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    checkOutput("rst_hz_hit", 32'(bus.hz_hit_o), 32'd0);

    // Single push, one-cycle latency to write
    applyStimulus(1'b1, 4'd3, 32'h11);
    tick();
    applyStimulus(1'b0, '0, '0);
    checkOutput("t1_count_after_push", 32'(bus.count_o), 32'd1);
    checkOutput("t1_no_bypass", 32'(bus.wb_en_o), 32'd0);
    tick();
    checkOutput("t1_wb_en", 32'(bus.wb_en_o), 32'd1);
    checkOutput("t1_wb_addr", 32'(bus.wb_address_o), 32'd3);
    checkOutput("t1_wb_data", bus.wb_data_o, 32'h11);
    tick();
    checkOutput("t1_wb_en_off", 32'(bus.wb_en_o), 32'd0);
    checkOutput("t1_wb_addr_hold", 32'(bus.wb_address_o), 32'd3);

    // Fill under drain_hold, overflow push ignored, then drain in order
    bus.drain_hold_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 4'(i), 32'h100 + 32'(i));
      tick();
    end
    checkOutput("t2_count_full", 32'(bus.count_o), 32'd4);
    checkOutput("t2_in_ready_full", 32'(bus.in_ready_o), 32'd0);
    applyStimulus(1'b1, 4'd9, 32'h999);
    tick();
    applyStimulus(1'b0, '0, '0);
    checkOutput("t2_count_after_5th", 32'(bus.count_o), 32'd4);
    bus.drain_hold_i = 1'b0;
    #1;
    checkOutput("t2_in_ready_full_popping", 32'(bus.in_ready_o), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("t2_drain_en", 32'(bus.wb_en_o), 32'd1);
      checkOutput("t2_drain_addr", 32'(bus.wb_address_o), 32'(i));
      checkOutput("t2_drain_data", bus.wb_data_o, 32'h100 + 32'(i));
    end
    tick();
    checkOutput("t2_drained_en", 32'(bus.wb_en_o), 32'd0);
    checkOutput("t2_drained_count", 32'(bus.count_o), 32'd0);

    // Streaming: one push and one pop per cycle, pointers wrap
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 4'(i), 32'h200 + 32'(i));
      tick();
      checkOutput("t3_count", 32'(bus.count_o), 32'd1);
      if (i > 0) begin
        checkOutput("t3_addr", 32'(bus.wb_address_o), 32'(i - 1));
        checkOutput("t3_data", bus.wb_data_o, 32'h200 + 32'(i - 1));
      end
    end
    applyStimulus(1'b0, '0, '0);
    tick();
    checkOutput("t3_last_addr", 32'(bus.wb_address_o), 32'd9);
    checkOutput("t3_last_data", bus.wb_data_o, 32'h209);
    checkOutput("t3_count_empty", 32'(bus.count_o), 32'd0);
    tick();

    // Duplicate address: hazard and youngest forward
    bus.drain_hold_i = 1'b1;
    applyStimulus(1'b1, 4'd5, 32'hA);
    tick();
    applyStimulus(1'b1, 4'd5, 32'hB);
    tick();
    applyStimulus(1'b0, '0, '0);
    bus.hz_src_i = 4'd5;
    #1;
    checkOutput("t4_hz_hit", 32'(bus.hz_hit_o), 32'd1);
    checkOutput("t4_fwd", bus.fwd_data_o, fwdExpect(32'hB));
    bus.drain_hold_i = 1'b0;
    tick();
    checkOutput("t4_first_data", bus.wb_data_o, 32'hA);
    checkOutput("t4_fwd_mid", bus.fwd_data_o, fwdExpect(32'hB));
    tick();
    checkOutput("t4_last_addr", 32'(bus.wb_address_o), 32'd5);
    checkOutput("t4_last_data", bus.wb_data_o, 32'hB);
    tick();
    checkOutput("t4_hz_clear", 32'(bus.hz_hit_o), 32'd0);

    // Reset mid-operation drops queued entries
    bus.drain_hold_i = 1'b1;
    for (int i = 10; i < 13; i++) begin
      applyStimulus(1'b1, 4'(i), 32'h300 + 32'(i));
      tick();
    end
    applyStimulus(1'b0, '0, '0);
    checkOutput("t5_count3", 32'(bus.count_o), 32'd3);
    bus.drain_hold_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_count_rst", 32'(bus.count_o), 32'd0);
    checkOutput("t5_wb_en_rst", 32'(bus.wb_en_o), 32'd0);
    checkOutput("t5_in_ready", 32'(bus.in_ready_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t5_no_write", 32'(bus.wb_en_o), 32'd0);
    end

    // Hazard from the wb stage alone
    applyStimulus(1'b1, 4'd7, 32'h77);
    tick();
    applyStimulus(1'b0, '0, '0);
    tick();
    bus.hz_src_i = 4'd7;
    #1;
    checkOutput("t6_count_empty", 32'(bus.count_o), 32'd0);
    checkOutput("t6_hz_hit_wb", 32'(bus.hz_hit_o), 32'd1);
    checkOutput("t6_fwd_wb", bus.fwd_data_o, fwdExpect(32'h77));
    tick();
    checkOutput("t6_hz_hit_gone", 32'(bus.hz_hit_o), 32'd0);
    checkOutput("t6_fwd_gone", bus.fwd_data_o, 32'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
